md_unit: RTL and testbench

- Multi-cycle multiply/divide unit for the P6 pipeline. It owns the HI/LO registers and sits in the E stage beside the ALU.
- Executes mult/multu/div/divu with fixed latencies and accepts mthi/mtlo writes.
- Drives busy and start_out. Downstream stall logic ANDs (busy | start_out) with "D-stage instruction is an MD-class instruction" to freeze the front end.

---
 rtl/md_unit.sv | 138 +++++++++++++
 tb/tb_md_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Operands are latched on start; the 64-bit result is formed combinationally
// from the latched values and committed to HI/LO when the countdown expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        start_out
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_sgn;
    logic [31:0] r_sgn;
    logic [63:0] result;

    assign busy      = (state_q == RUN);
    assign start_out = start & ~busy;
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Result datapath from latched operands. Signed division runs on
    // magnitudes and re-applies signs, so 0x80000000 / -1 yields 0x80000000
    // without relying on signed-overflow behaviour of the divide operator.
    always_comb begin
        prod_s     = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u     = {32'd0, a_q} * {32'd0, b_q};
        div_zero   = (b_q == '0);
        div_signed = (op_q == OP_DIV);
        dividend   = (div_signed && a_q[31]) ? -a_q : a_q;
        divisor    = div_zero ? 32'd1 : ((div_signed && b_q[31]) ? -b_q : b_q);
        q_mag      = dividend / divisor;
        r_mag      = dividend % divisor;
        q_sgn      = (a_q[31] ^ b_q[31]) ? -q_mag : q_mag;
        r_sgn      = a_q[31] ? -r_mag : r_mag;
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {r_sgn, q_sgn};
            OP_DIVU:  result = {r_mag, q_mag};
            default:  result = '0;
        endcase
    end

    // Next-state logic: start latching, countdown, HI/LO commit, mthi/mtlo.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = op[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                    state_d = RUN;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    state_d = IDLE;
                    if (!(op_q[1] && div_zero)) begin
                        hi_d = result[63:32];
                        lo_d = result[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: expected HI/LO pairs are queued when an operation or
// mthi/mtlo is driven and popped when the unit finishes.
module tb_md_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        start_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] exp_q[$];

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .hi(hi), .lo(lo), .busy(busy), .start_out(start_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model of one operation given the current HI/LO.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] oh,
                                          input logic [31:0] ol);
        logic signed [63:0] sx, sy;
        int qi, ri;
        case (o)
            2'b00: begin
                sx = $signed(x);
                sy = $signed(y);
                return sx * sy;
            end
            2'b01: return {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) return {oh, ol};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qi = int'(x) / int'(y);
                ri = int'(x) % int'(y);
                return {ri, qi};
            end
            default: begin
                if (y == 32'd0) return {oh, ol};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Wait for busy to drop; hi/lo must hold pre-op values while busy.
    task automatic wait_done(input int already, input int n_exp);
        int cnt;
        logic [63:0] e;
        cnt = already;
        while (busy === 1'b1 && cnt < 200) begin
            check("hold_hi", hi, m_hi);
            check("hold_lo", lo, m_lo);
            cnt++;
            @(negedge clk);
        end
        check("busy_cycles", cnt, n_exp);
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("hi", hi, e[63:32]);
            check("lo", lo, e[31:0]);
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
        check("busy_after", busy, 0);
    endtask

    // Issue one operation from idle at a negedge and follow it to completion.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        #1;
        check("start_out_idle", start_out, 1);
        exp_q.push_back(model(o, x, y, m_hi, m_lo));
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        wait_done(0, o[1] ? DC : MC);
    endtask

    // mthi/mtlo from idle.
    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        hi_we = hw; lo_we = lw; wdata = d;
        exp_q.push_back({hw ? d : m_hi, lw ? d : m_lo});
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        wait_done(0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rst_hi", hi, 0);
            check("rst_lo", lo, 0);
            check("rst_busy", busy, 0);
            check("rst_start_out", start_out, 0);
            @(negedge clk);
        end

        do_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
        do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002);
        do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        do_op(2'b11, 32'd7, 32'd0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b10, 32'd100, 32'd0);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE);

        // start and mthi while busy are ignored
        mt(1'b1, 1'b1, 32'h0);
        op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1;
        exp_q.push_back(model(2'b00, 32'd3, 32'd4, m_hi, m_lo));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        op = 2'b11; start = 1'b1; hi_we = 1'b1; wdata = 32'hAA;
        #1;
        check("start_out_busy", start_out, 0);
        check("busy_mid", busy, 1);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        wait_done(2, MC);

        // reset mid-operation abandons the divide
        op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_hi", hi, 0);
        check("midrst_lo", lo, 0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        check("midrst_idle", busy, 0);
        mt(1'b0, 1'b1, 32'h55);

        // start wins over same-cycle mtlo
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1; lo_we = 1'b1; wdata = 32'h99;
        exp_q.push_back(model(2'b00, 32'd2, 32'd3, m_hi, m_lo));
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        wait_done(0, MC);
        mt(1'b1, 1'b1, 32'h1234);

        // randomised operations
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 3 == 0) ? $urandom_range(0, 9) : $urandom;
            do_op(2'($urandom_range(0, 3)), ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
